// File: rtl/win_addr_pkg.sv
// Shared types and default widths for the window address generator.
package win_addr_pkg;

    localparam int unsigned COORD_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/window_addr_if.sv
// Request/configuration and address-beat bus between a requester and window_addr_gen.
interface window_addr_if #(
    parameter int unsigned COORD_W = win_addr_pkg::COORD_W_DEF,
    parameter int unsigned ADDR_W  = win_addr_pkg::ADDR_W_DEF
);
    logic               start;
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] width;
    logic [COORD_W-1:0] height;
    logic [COORD_W-1:0] rows;
    logic [COORD_W-1:0] cols;
    logic               ready;
    logic [ADDR_W-1:0]  addr;
    logic               valid;
    logic               oob;
    logic               last;
    logic               busy;
    logic               done;

    modport master (
        output start, x0, y0, width, height, rows, cols, ready,
        input  addr, valid, oob, last, busy, done
    );

    modport slave (
        input  start, x0, y0, width, height, rows, cols, ready,
        output addr, valid, oob, last, busy, done
    );
endinterface

// File: rtl/addr_counter2d.sv
// Nested row/column beat counter; exposes the next (i,j), the row wrap and whether the next beat is last.
module addr_counter2d #(
    parameter int unsigned W = win_addr_pkg::COORD_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         advance,
    input  logic [W-1:0] rows,
    input  logic [W-1:0] cols,
    output logic [W-1:0] i_nxt_c,
    output logic [W-1:0] j_nxt_c,
    output logic         row_wrap_c,
    output logic         last_nxt_c
);
    logic [W-1:0] i_q, i_d;
    logic [W-1:0] j_q, j_d;

    always_comb begin
        i_d        = i_q;
        j_d        = j_q;
        row_wrap_c = 1'b0;
        if (load) begin
            i_d = '0;
            j_d = '0;
        end else if (advance) begin
            if (j_q == cols - W'(1)) begin
                j_d        = '0;
                i_d        = i_q + W'(1);
                row_wrap_c = 1'b1;
            end else begin
                j_d = j_q + W'(1);
            end
        end
    end

    assign i_nxt_c    = i_d;
    assign j_nxt_c    = j_d;
    assign last_nxt_c = (i_d == rows - W'(1)) && (j_d == cols - W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q <= '0;
            j_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
        end
    end
endmodule

// File: rtl/window_addr_gen.sv
// Row-major window scanner: emits (X0+i)*Width + (Y0+j) beats with valid/ready flow control.
module window_addr_gen
    import win_addr_pkg::*;
#(
    parameter int unsigned COORD_W = COORD_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
    input  logic        Clk,
    input  logic        Reset_n,
    window_addr_if.slave bus
);
    localparam int unsigned PROD_W = 2 * COORD_W;
    localparam int unsigned CMP_W  = COORD_W + 1;

    state_e state_q, state_d;

    logic [COORD_W-1:0] x0_q, x0_d, y0_q, y0_d;
    logic [COORD_W-1:0] width_q, width_d, height_q, height_d;
    logic [COORD_W-1:0] rows_q, rows_d, cols_q, cols_d;
    logic [ADDR_W-1:0]  row_base_q, row_base_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               valid_q, valid_d, oob_q, oob_d, last_q, last_d;
    logic               busy_q, busy_d, done_q, done_d;

    logic               cnt_load, cnt_adv, emit, retire;
    logic [COORD_W-1:0] i_nxt, j_nxt;
    logic               row_wrap, last_nxt;
    logic [CMP_W-1:0]   row_c, col_c;

    addr_counter2d #(.W(COORD_W)) u_cnt (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .load       (cnt_load),
        .advance    (cnt_adv),
        .rows       (rows_d),
        .cols       (cols_d),
        .i_nxt_c    (i_nxt),
        .j_nxt_c    (j_nxt),
        .row_wrap_c (row_wrap),
        .last_nxt_c (last_nxt)
    );

    // Control: state transitions, configuration capture and row-base accumulation.
    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        width_d    = width_q;
        height_d   = height_q;
        rows_d     = rows_q;
        cols_d     = cols_q;
        row_base_d = row_base_q;
        valid_d    = valid_q;
        cnt_load   = 1'b0;
        cnt_adv    = 1'b0;
        emit       = 1'b0;
        retire     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    x0_d     = bus.x0;
                    y0_d     = bus.y0;
                    width_d  = bus.width;
                    height_d = bus.height;
                    rows_d   = bus.rows;
                    cols_d   = bus.cols;
                    if ((bus.rows != '0) && (bus.cols != '0)) begin
                        state_d    = ST_RUN;
                        cnt_load   = 1'b1;
                        row_base_d = ADDR_W'(PROD_W'(bus.x0) * PROD_W'(bus.width));
                        valid_d    = 1'b1;
                        emit       = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (valid_q && bus.ready) begin
                    if (last_q) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        retire  = 1'b1;
                    end else begin
                        cnt_adv = 1'b1;
                        emit    = 1'b1;
                        if (row_wrap) begin
                            row_base_d = row_base_q + ADDR_W'(width_q);
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // Beat datapath: address and frame-bounds test for the beat about to be presented.
    always_comb begin
        col_c  = CMP_W'(y0_d) + CMP_W'(j_nxt);
        row_c  = CMP_W'(x0_d) + CMP_W'(i_nxt);
        addr_d = addr_q;
        oob_d  = oob_q;
        last_d = last_q;
        if (emit) begin
            addr_d = row_base_d + ADDR_W'(col_c);
            oob_d  = (row_c >= CMP_W'(height_d)) || (col_c >= CMP_W'(width_d));
            last_d = last_nxt;
        end else if (retire) begin
            addr_d = '0;
            oob_d  = 1'b0;
            last_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            x0_q       <= '0;
            y0_q       <= '0;
            width_q    <= '0;
            height_q   <= '0;
            rows_q     <= '0;
            cols_q     <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            oob_q      <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            width_q    <= width_d;
            height_q   <= height_d;
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            oob_q      <= oob_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.addr  = addr_q;
    assign bus.valid = valid_q;
    assign bus.oob   = oob_q;
    assign bus.last  = last_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: doc/window_addr_gen.md
WINDOW_ADDR_GEN -- requirements
Module: window_addr_gen

Interface
REQ-001 Parameter COORD_W, default 8: width of coordinate, frame-dimension and window-dimension inputs.
REQ-002 Parameter ADDR_W, default 16: width of the linear address output.
REQ-003 Clk  input  1  sole clock, rising-edge.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  request a new window scan; sampled only in IDLE.
REQ-006 X0, Y0  input  COORD_W each  window origin; X0 is the row, Y0 is the column.
REQ-007 Width, Height  input  COORD_W each  frame dimensions.
REQ-008 Rows, Cols  input  COORD_W each  window dimensions.
REQ-009 Addr  output  ADDR_W  linear address (X0+i)*Width + (Y0+j).
REQ-010 Valid  output  1  Addr beat present.
REQ-011 Ready  input  1  downstream accepts the beat when Valid and Ready are both high.
REQ-012 Oob  output  1  current beat lies outside the frame.
REQ-013 Last  output  1  current beat is the final beat of the window.
REQ-014 Busy  output  1  scan in progress.
REQ-015 Done  output  1  one-cycle pulse on scan completion.

Function
REQ-016 FSM states are IDLE, RUN and DONE.
- IDLE->RUN on Start with Rows!=0 and Cols!=0.
- IDLE->DONE on Start with Rows==0 or Cols==0; no beats are emitted.
- RUN->DONE on acceptance of the Last beat.
- DONE->IDLE unconditionally after one cycle.
REQ-017 On Start acceptance, all inputs are registered; input changes afterwards do not affect the scan in progress.
REQ-018 Row base is computed as X0*Width when Start is accepted, then incremented by Width at each row change; no per-beat multiply.
REQ-019 The first Valid occurs on the cycle after Start acceptance (latency 1).
REQ-020 Scan order is row-major: j runs 0..Cols-1 within each row i, and i runs 0..Rows-1.
REQ-021 Exactly one beat advances per cycle in which Valid and Ready are both high.
REQ-022 While Valid is high and Ready is low, Addr, Oob and Last hold stable.
REQ-023 Oob=1 when X0+i >= Height or Y0+j >= Width, computed at COORD_W+1 bits; the Addr beat is still emitted.
REQ-024 Addr arithmetic is unsigned, computed at full width, then truncated modulo 2^ADDR_W.
REQ-025 Last=1 only on the beat with i=Rows-1 and j=Cols-1.
REQ-026 Busy=1 in RUN only.
REQ-027 Done=1 in DONE only.
REQ-028 Start is ignored in RUN and DONE.
REQ-029 A Start held high over consecutive cycles in IDLE launches one scan per IDLE visit.

Reset
REQ-030 Asserting Reset_n low clears the FSM to IDLE and drives Addr, Valid, Oob, Last, Busy and Done to 0 immediately, including mid-scan.
REQ-031 After Reset_n deasserts, the block waits in IDLE for a new Start; the interrupted scan is not resumed.

Structure
REQ-032 Shared package win_addr_pkg holds the FSM state enum and the default values of COORD_W and ADDR_W.
REQ-033 The nested i/j counter, including wrap and Last detection, lives in one sub-module addr_counter2d; the top level owns the FSM, row-base accumulator, Oob compare and output registers.

Verification
REQ-034 Single beat: Width=64, Height=64, X0=1, Y0=2, Rows=1, Cols=1, Ready=1 -> one beat with Addr=66, Last=1, Oob=0; Done pulses the following cycle.
REQ-035 Column edge: Width=64, Height=64, X0=45, Y0=62, Rows=2, Cols=3 -> beats 2942, 2943, 2944(Oob), 3006, 3007, 3008(Oob, Last).
REQ-036 Backpressure: 1x4 window at X0=0, Y0=0, Width=64, Ready low for two cycles on beat 2 -> Addr holds at 1; sequence is 0, 1, 2, 3; no beat is lost or duplicated.
REQ-037 Empty window: Rows=0, Cols=5 -> Valid never asserts; Done pulses 1 cycle after Start; Busy stays 0.
REQ-038 Reset mid-scan: Reset_n pulsed low on beat 3 of an 8-beat window -> all outputs are 0 without waiting for a Clk edge; a new Start runs a full, correct scan.
REQ-039 Start ignored: Start pulsed during RUN with different X0 -> the current scan completes unchanged and no second scan follows.
